// File: rtl/tlb_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_miss_ctrl
//  Description : TLB lookup / miss controller shared by ITLB and DTLB.
//                Classifies each request as bare bypass, hit, permission
//                fault or miss; on a miss it runs the PTW request/response
//                handshake and issues a round-robin refill write. The
//                response is held until the consumer accepts it. Saturating
//                hit/miss performance counters.
//  Ports       : clk_i, rstn_i          clock, async active-low reset
//                satp_i, priv_u_i       translation mode / privilege
//                req_*                  lookup request (valid/ready, vpn, store)
//                tag_hit_i, hit_flags_i CAM result for the request cycle
//                ptw_req_* / ptw_resp_* page-table walker handshake
//                refill_we_o/idx_o      TLB entry write on refill
//                flush_i / flush_o      sfence.vma in, invalidate-all out
//                resp_*                 lookup response (valid/ready, hit, fault)
//                hit_cnt_o/miss_cnt_o   saturating counters
//  Revision    : 1.0  initial release
// ============================================================================
module tlb_miss_ctrl #(
  parameter int VPN_W   = 27,
  parameter int ENTRIES = 8,
  parameter int IS_ITLB = 1,
  parameter int CNT_W   = 32,
  parameter int MXLEN   = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [MXLEN-1:0]           satp_i,
  input  logic                       priv_u_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [VPN_W-1:0]           req_vpn_i,
  input  logic                       req_store_i,
  input  logic                       tag_hit_i,
  input  logic [7:0]                 hit_flags_i,
  output logic                       ptw_req_valid_o,
  input  logic                       ptw_req_ready_i,
  output logic [VPN_W-1:0]           ptw_req_vpn_o,
  input  logic                       ptw_resp_valid_i,
  input  logic                       ptw_resp_fault_i,
  input  logic [7:0]                 ptw_resp_flags_i,
  output logic                       refill_we_o,
  output logic [$clog2(ENTRIES)-1:0] refill_idx_o,
  input  logic                       flush_i,
  output logic                       flush_o,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic                       resp_hit_o,
  output logic                       resp_fault_o,
  output logic [CNT_W-1:0]           hit_cnt_o,
  output logic [CNT_W-1:0]           miss_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PTW_REQ  = 3'd1,
    S_PTW_WAIT = 3'd2,
    S_REFILL   = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic               priv_u_q, priv_u_d;
  logic               store_q, store_d;
  logic               hit_q, hit_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               flush_o_q, flush_o_d;

  logic               satp_bare;
  logic               ok_hit;
  logic               ok_walk;
  logic               flush_seen;

  // satp.MODE position depends on XLEN: bit 31 on RV32, bits 63:60 on RV64.
  if (MXLEN == 32) begin : g_satp32
    logic unused_satp;
    assign satp_bare   = ~satp_i[31];
    assign unused_satp = ^satp_i[30:0];
  end else begin : g_satp64
    logic unused_satp;
    assign satp_bare   = ~|satp_i[MXLEN-1 -: 4];
    assign unused_satp = ^satp_i[MXLEN-5:0];
  end

  // The global bit plays no part in the permission check.
  logic unused_gbits;
  assign unused_gbits = hit_flags_i[5] ^ ptw_resp_flags_i[5];

  // Flags are {D,A,G,U,X,W,R,V}. W without R is a reserved encoding.
  function automatic logic perm_ok(input logic [7:0] f, input logic u, input logic st);
    logic acc;
    if (IS_ITLB != 0) acc = f[3];
    else              acc = st ? (f[1] & f[2] & f[7]) : f[1];
    return f[0] & f[6] & ~(f[2] & ~f[1]) & (u ? f[4] : ~f[4]) & acc;
  endfunction

  // Hit path sees the live request attributes; the walk path uses the
  // values captured at accept so mid-walk input changes do not matter.
  assign ok_hit     = perm_ok(hit_flags_i, priv_u_i, req_store_i);
  assign ok_walk    = perm_ok(ptw_resp_flags_i, priv_u_q, store_q);
  assign flush_seen = flush_pend_q | flush_i;

  always_comb begin
    state_d      = state_q;
    vpn_d        = vpn_q;
    priv_u_d     = priv_u_q;
    store_d      = store_q;
    hit_d        = hit_q;
    fault_d      = fault_q;
    ptr_d        = ptr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    flush_pend_d = flush_pend_q;
    flush_o_d    = 1'b0;

    // A flush outside IDLE is deferred until the controller is idle again.
    if (state_q != S_IDLE && flush_i) flush_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          flush_o_d = 1'b1;
          ptr_d     = '0;
        end else if (req_valid_i) begin
          priv_u_d = priv_u_i;
          store_d  = req_store_i;
          state_d  = S_RESP;
          if (satp_bare) begin
            hit_d   = 1'b1;
            fault_d = 1'b0;
          end else if (tag_hit_i) begin
            hit_d   = ok_hit;
            fault_d = ~ok_hit;
            if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            vpn_d   = req_vpn_i;
            state_d = S_PTW_REQ;
            if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      S_PTW_REQ: begin
        if (ptw_req_ready_i) state_d = S_PTW_WAIT;
      end
      S_PTW_WAIT: begin
        if (ptw_resp_valid_i) begin
          if (ptw_resp_fault_i) begin
            hit_d   = 1'b0;
            fault_d = 1'b1;
            state_d = S_RESP;
          end else begin
            hit_d   = ok_walk;
            fault_d = ~ok_walk;
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        // The victim pointer only advances when the write really happens.
        if (!flush_seen) ptr_d = ptr_q + 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          if (flush_seen) begin
            flush_o_d    = 1'b1;
            ptr_d        = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      vpn_q        <= '0;
      priv_u_q     <= 1'b0;
      store_q      <= 1'b0;
      hit_q        <= 1'b0;
      fault_q      <= 1'b0;
      ptr_q        <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      flush_o_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      priv_u_q     <= priv_u_d;
      store_q      <= store_d;
      hit_q        <= hit_d;
      fault_q      <= fault_d;
      ptr_q        <= ptr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      flush_pend_q <= flush_pend_d;
      flush_o_q    <= flush_o_d;
    end
  end

  // A same-cycle flush takes priority over a new request.
  assign req_ready_o     = (state_q == S_IDLE) & ~flush_i;
  assign ptw_req_valid_o = (state_q == S_PTW_REQ);
  assign ptw_req_vpn_o   = vpn_q;
  assign refill_we_o     = (state_q == S_REFILL) & ~flush_seen;
  assign refill_idx_o    = ptr_q;
  assign flush_o         = flush_o_q;
  assign resp_valid_o    = (state_q == S_RESP);
  assign resp_hit_o      = (state_q == S_RESP) & hit_q;
  assign resp_fault_o    = (state_q == S_RESP) & fault_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlb_miss_ctrl
//  Description : Self-checking bench for tlb_miss_ctrl (ITLB flavour,
//                narrow counters so saturation is reachable).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tlb_miss_ctrl;

  localparam int CW = 3;
  localparam logic [63:0] SV39 = 64'h8000_0000_0000_0000;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic [63:0]     satp_i;
  logic            priv_u_i, req_valid_i, req_ready_o, req_store_i, tag_hit_i;
  logic [26:0]     req_vpn_i, ptw_req_vpn_o;
  logic [7:0]      hit_flags_i, ptw_resp_flags_i;
  logic            ptw_req_valid_o, ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_fault_i;
  logic            refill_we_o, flush_i, flush_o, resp_valid_o, resp_ready_i;
  logic [2:0]      refill_idx_o;
  logic            resp_hit_o, resp_fault_o;
  logic [CW-1:0]   hit_cnt_o, miss_cnt_o;

  always #5 clk_i = ~clk_i;

  tlb_miss_ctrl #(.VPN_W(27), .ENTRIES(8), .IS_ITLB(1), .CNT_W(CW), .MXLEN(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .satp_i(satp_i), .priv_u_i(priv_u_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vpn_i(req_vpn_i),
    .req_store_i(req_store_i), .tag_hit_i(tag_hit_i), .hit_flags_i(hit_flags_i),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_resp_valid_i(ptw_resp_valid_i),
    .ptw_resp_fault_i(ptw_resp_fault_i), .ptw_resp_flags_i(ptw_resp_flags_i),
    .refill_we_o(refill_we_o), .refill_idx_o(refill_idx_o), .flush_i(flush_i),
    .flush_o(flush_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_fault_o(resp_fault_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] satp;
    logic        pu;
    logic [26:0] vpn;
    logic        th;
    logic [7:0]  fl;
    logic        eh;
    logic        ef;
  } vec_t;

  vec_t vecs[10];

  // Miss sequence with configurable walker ready delay, mid-walk flush,
  // walk fault and response back-pressure.
  task automatic run_miss(input logic [26:0] vpn, input logic u, input logic [7:0] flags,
                          input logic wfault, input int rdy_dly, input logic flush_wait,
                          input logic exp_refill, input logic [2:0] exp_idx,
                          input logic exp_hit, input int hold);
    @(negedge clk_i);
    satp_i = SV39; priv_u_i = u; req_vpn_i = vpn; tag_hit_i = 1'b0; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_vpn_i = '0; satp_i = '0; priv_u_i = ~u;
    if (exp_miss < 7) exp_miss++;
    chk("miss_ptw_valid", ptw_req_valid_o, 1'b1);
    chk("miss_ptw_vpn", ptw_req_vpn_o, vpn);
    chk("miss_ready_low", req_ready_o, 1'b0);
    chk("miss_cnt", miss_cnt_o, exp_miss);
    for (int i = 0; i < rdy_dly; i++) begin
      @(posedge clk_i); #1;
      chk("ptw_hold", {ptw_req_valid_o, ptw_req_vpn_o}, {1'b1, vpn});
    end
    @(negedge clk_i); ptw_req_ready_i = 1'b1;
    @(posedge clk_i); #1; ptw_req_ready_i = 1'b0;
    chk("ptw_req_dropped", ptw_req_valid_o, 1'b0);
    @(negedge clk_i); flush_i = flush_wait;
    @(posedge clk_i); #1; flush_i = 1'b0;
    @(negedge clk_i);
    ptw_resp_valid_i = 1'b1; ptw_resp_fault_i = wfault; ptw_resp_flags_i = flags;
    @(posedge clk_i); #1; ptw_resp_valid_i = 1'b0; ptw_resp_fault_i = 1'b0;
    if (!wfault) begin
      chk("refill_we", refill_we_o, exp_refill);
      if (exp_refill) chk("refill_idx", refill_idx_o, exp_idx);
      @(posedge clk_i); #1;
    end
    chk("walk_resp", {resp_valid_o, resp_hit_o, resp_fault_o, refill_we_o},
        {1'b1, exp_hit, ~exp_hit, 1'b0});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      chk("resp_held", {resp_valid_o, resp_hit_o, resp_fault_o}, {1'b1, exp_hit, ~exp_hit});
    end
    @(negedge clk_i); resp_ready_i = 1'b1;
    @(posedge clk_i); #1; resp_ready_i = 1'b0;
    chk("walk_resp_done", resp_valid_o, 1'b0);
    chk("flush_o_after_resp", flush_o, flush_wait);
    satp_i = SV39; priv_u_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    // flags {D,A,G,U,X,W,R,V}
    vecs[0] = '{64'h0, 1'b0, 27'h1234,  1'b0, 8'h00, 1'b1, 1'b0}; // bare
    vecs[1] = '{SV39,  1'b0, 27'h00100, 1'b1, 8'hCF, 1'b1, 1'b0}; // S fetch ok
    vecs[2] = '{SV39,  1'b1, 27'h00200, 1'b1, 8'hD7, 1'b0, 1'b1}; // U, X clear
    vecs[3] = '{SV39,  1'b1, 27'h00300, 1'b1, 8'hDF, 1'b1, 1'b0}; // U page, U mode
    vecs[4] = '{SV39,  1'b0, 27'h00400, 1'b1, 8'hDF, 1'b0, 1'b1}; // U page, S mode
    vecs[5] = '{SV39,  1'b0, 27'h00500, 1'b1, 8'hCE, 1'b0, 1'b1}; // V clear
    vecs[6] = '{SV39,  1'b0, 27'h00600, 1'b1, 8'h8F, 1'b0, 1'b1}; // A clear
    vecs[7] = '{SV39,  1'b0, 27'h00700, 1'b1, 8'hCD, 1'b0, 1'b1}; // W without R
    vecs[8] = '{SV39,  1'b0, 27'h00800, 1'b1, 8'hC9, 1'b1, 1'b0}; // execute-only
    vecs[9] = '{64'h0, 1'b0, 27'h00900, 1'b1, 8'h00, 1'b1, 1'b0}; // bare ignores CAM

    rstn_i = 1'b0; satp_i = '0; priv_u_i = 1'b0; req_valid_i = 1'b0; req_vpn_i = '0;
    req_store_i = 1'b0; tag_hit_i = 1'b0; hit_flags_i = '0; ptw_req_ready_i = 1'b0;
    ptw_resp_valid_i = 1'b0; ptw_resp_fault_i = 1'b0; ptw_resp_flags_i = '0;
    flush_i = 1'b0; resp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ready", req_ready_o, 1'b1);
    chk("reset_outs", {ptw_req_valid_o, refill_we_o, flush_o, resp_valid_o, resp_hit_o,
                       resp_fault_o, refill_idx_o, ptw_req_vpn_o}, '0);
    chk("reset_cnts", {hit_cnt_o, miss_cnt_o}, '0);
    @(negedge clk_i); rstn_i = 1'b1;

    // Single-cycle lookups, response accepted in the cycle it is raised.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk_i);
      satp_i = vecs[v].satp; priv_u_i = vecs[v].pu; req_vpn_i = vecs[v].vpn;
      tag_hit_i = vecs[v].th; hit_flags_i = vecs[v].fl; req_valid_i = 1'b1;
      #1;
      chk("vec_ready", req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0; resp_ready_i = 1'b1;
      if (vecs[v].satp != 0 && vecs[v].th && exp_hits < 7) exp_hits++;
      chk($sformatf("vec%0d_resp", v),
          {resp_valid_o, resp_hit_o, resp_fault_o, ptw_req_valid_o},
          {1'b1, vecs[v].eh, vecs[v].ef, 1'b0});
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
      chk($sformatf("vec%0d_done", v), resp_valid_o, 1'b0);
      chk($sformatf("vec%0d_cnts", v), {hit_cnt_o, miss_cnt_o}, {exp_hits[CW-1:0], exp_miss[CW-1:0]});
    end
    chk("hit_cnt_saturated", hit_cnt_o, 3'd7);

    // Walks: delayed walker ready, refill at idx 0 then idx 1.
    run_miss(27'h0ABCDE, 1'b0, 8'hCB, 1'b0, 3, 1'b0, 1'b1, 3'd0, 1'b1, 0);
    run_miss(27'h012345, 1'b0, 8'hCB, 1'b0, 0, 1'b0, 1'b1, 3'd1, 1'b1, 0);
    chk("ptr_after_two", refill_idx_o, 3'd2);

    // Flush in IDLE blocks a same-cycle request and resets the victim pointer.
    @(negedge clk_i);
    satp_i = SV39; tag_hit_i = 1'b1; hit_flags_i = 8'hCF; flush_i = 1'b1; req_valid_i = 1'b1;
    #1;
    chk("flush_idle_ready", req_ready_o, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    chk("flush_idle_pulse", {flush_o, resp_valid_o, refill_idx_o}, {1'b1, 1'b0, 3'd0});
    chk("flush_idle_cnt", hit_cnt_o, 3'd7);
    @(posedge clk_i); #1;
    chk("flush_pulse_end", flush_o, 1'b0);

    // Refill after flush lands at idx 0; then flush during the walk.
    run_miss(27'h000777, 1'b0, 8'hCB, 1'b0, 1, 1'b0, 1'b1, 3'd0, 1'b1, 0);
    run_miss(27'h000888, 1'b0, 8'hCB, 1'b0, 0, 1'b1, 1'b0, 3'd0, 1'b1, 0);
    chk("ptr_after_flush", refill_idx_o, 3'd0);

    // Walk fault with response back-pressure for 4 cycles.
    run_miss(27'h000999, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 3'd0, 1'b0, 4);

    // Asynchronous reset in the middle of a walk.
    @(negedge clk_i);
    satp_i = SV39; tag_hit_i = 1'b0; req_vpn_i = 27'h55; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("prereset_walk", ptw_req_valid_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    chk("async_reset", {req_ready_o, ptw_req_valid_o, resp_valid_o, hit_cnt_o, miss_cnt_o},
        {1'b1, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}});
    @(negedge clk_i); rstn_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
